// File: rtl/int_to_fp_prenorm_pipe.sv
// int_to_fp_prenorm_pipe: front half of the INT->FP convert path.
// S1 widens the operand to 64 bits and takes its absolute value.
// S2 counts leading zeros and left-normalises, dropping the leading 1.
// rm and tag ride along unchanged. Valid/ready handshake, 1 op/cycle.
module int_to_fp_prenorm_pipe #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [63:0]      int_i,
  input  logic             is_signed_i,
  input  logic             is_long_i,
  input  logic [2:0]       rm_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [62:0]      norm_int_o,
  output logic [5:0]       lzc_o,
  output logic             is_zero_o,
  output logic             sign_o,
  output logic [2:0]       rm_o,
  output logic [TAG_W-1:0] tag_o
);

  // ---------------- handshake ----------------
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s1_en, s2_en, in_fire, s2_load;

  assign s2_en      = !s2_vld_q | out_ready_i;
  assign s1_en      = !s1_vld_q | s2_en;
  assign in_ready_o = s1_en & !flush_i;
  assign in_fire    = in_valid_i & in_ready_o;
  // S2 only loads when something real moves up; flush blocks the move.
  assign s2_load    = s2_en & s1_vld_q & !flush_i;

  // Valid bits: flush empties both stages, otherwise advance on stage enable.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (flush_i) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else begin
      if (s1_en) s1_vld_d = in_fire;
      if (s2_en) s2_vld_d = s1_vld_q;
    end
  end

  // Valid registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // ---------------- S1: widen + abs ----------------
  logic [63:0]      ext;
  logic             s1_sign_d, s1_zero_d;
  logic [63:0]      s1_abs_d;
  logic             s1_sign_q, s1_zero_q;
  logic [63:0]      s1_abs_q;
  logic [2:0]       s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Widen to 64 bits (upper half ignored for 32-bit ops) and take magnitude.
  // -2^63 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    ext = int_i;
    if (!is_long_i) begin
      if (is_signed_i) ext = {{32{int_i[31]}}, int_i[31:0]};
      else             ext = {32'b0, int_i[31:0]};
    end
    s1_sign_d = is_signed_i & ext[63];
    s1_abs_d  = s1_sign_d ? (~ext + 64'd1) : ext;
    s1_zero_d = (ext == 64'd0);
  end

  // S1 data registers capture only on an accepted input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_abs_q  <= '0;
      s1_rm_q   <= '0;
      s1_tag_q  <= '0;
    end else if (in_fire) begin
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_abs_q  <= s1_abs_d;
      s1_rm_q   <= rm_i;
      s1_tag_q  <= tag_i;
    end
  end

  // ---------------- S2: LZC + shift ----------------
  logic [5:0]       lzc_d;
  logic [62:0]      norm_d;
  logic             found;
  logic [5:0]       s2_lzc_q;
  logic [62:0]      s2_norm_q;
  logic             s2_sign_q, s2_zero_q;
  logic [2:0]       s2_rm_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Priority scan from the MSB; zero magnitude leaves lzc=0 and norm=0.
  // Bit 63 of the shifted value is always the dropped leading 1, so only
  // abs[62:0] needs shifting.
  always_comb begin
    lzc_d = '0;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && s1_abs_q[i]) begin
        lzc_d = 6'(63 - i);
        found = 1'b1;
      end
    end
    norm_d = s1_abs_q[62:0] << lzc_d;
  end

  // S2 output registers; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_lzc_q  <= '0;
      s2_norm_q <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_rm_q   <= '0;
      s2_tag_q  <= '0;
    end else if (s2_load) begin
      s2_lzc_q  <= lzc_d;
      s2_norm_q <= norm_d;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_rm_q   <= s1_rm_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  assign out_valid_o = s2_vld_q;
  assign norm_int_o  = s2_norm_q;
  assign lzc_o       = s2_lzc_q;
  assign is_zero_o   = s2_zero_q;
  assign sign_o      = s2_sign_q;
  assign rm_o        = s2_rm_q;
  assign tag_o       = s2_tag_q;

endmodule

// File: tb/tb_int_to_fp_prenorm_pipe.sv
// Directed bench for int_to_fp_prenorm_pipe: hand-computed conversions,
// latency, backpressure, flush and mid-stream reset.
module tb_int_to_fp_prenorm_pipe;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [63:0]      int_i = '0;
  logic             is_signed_i = 1'b0;
  logic             is_long_i = 1'b0;
  logic [2:0]       rm_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [62:0]      norm_int_o;
  logic [5:0]       lzc_o;
  logic             is_zero_o;
  logic             sign_o;
  logic [2:0]       rm_o;
  logic [TAG_W-1:0] tag_o;

  int nvec = 0;
  int nerr = 0;

  int_to_fp_prenorm_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .int_i(int_i), .is_signed_i(is_signed_i), .is_long_i(is_long_i),
    .rm_i(rm_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .norm_int_o(norm_int_o), .lzc_o(lzc_o), .is_zero_o(is_zero_o),
    .sign_o(sign_o), .rm_o(rm_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, obs, expv);
    end
  endtask

  task automatic drive(input logic [63:0] v, input logic s, input logic l,
                       input logic [2:0] rm, input logic [7:0] tg);
    int_i = v; is_signed_i = s; is_long_i = l; rm_i = rm; tag_i = tg;
    in_valid_i = 1'b1;
  endtask

  // One op with free-flowing output: checks 2-cycle latency and all fields.
  task automatic conv(input string nm, input logic [63:0] v, input logic s, input logic l,
                      input logic [2:0] rm, input logic [7:0] tg,
                      input logic esign, input logic [5:0] elzc,
                      input logic [62:0] enorm, input logic ezero);
    @(negedge clk); drive(v, s, l, rm, tg);
    @(negedge clk); in_valid_i = 1'b0;
    chk({nm, "_lat1"}, 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk({nm, "_vld"},  64'(out_valid_o), 64'd1);
    chk({nm, "_sign"}, 64'(sign_o), 64'(esign));
    chk({nm, "_lzc"},  64'(lzc_o), 64'(elzc));
    chk({nm, "_norm"}, 64'(norm_int_o), 64'(enorm));
    chk({nm, "_zero"}, 64'(is_zero_o), 64'(ezero));
    chk({nm, "_rm"},   64'(rm_o), 64'(rm));
    chk({nm, "_tag"},  64'(tag_o), 64'(tg));
  endtask

  logic [63:0] sv [4];
  logic [5:0]  slzc [4];
  logic [7:0]  stag [4];

  initial begin
    int sent, got, held;
    logic acc;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  64'(out_valid_o), 64'd0);
    chk("rst_norm", 64'(norm_int_o), 64'd0);
    chk("rst_lzc",  64'(lzc_o), 64'd0);
    chk("rst_flags", {61'd0, sign_o, is_zero_o, 1'b0}, 64'd0);
    chk("rst_tag",  64'({rm_o, tag_o}), 64'd0);
    rst_n = 1'b1;

    // ---- directed conversions ----
    conv("s32_m1",   64'h0000_0000_FFFF_FFFF, 1, 0, 3'd1, 8'h11, 1, 6'd63, 63'd0, 0);
    conv("u64_3",    64'h0000_0000_0000_0003, 0, 1, 3'd2, 8'h12, 0, 6'd62, 63'h4000_0000_0000_0000, 0);
    conv("s64_min",  64'h8000_0000_0000_0000, 1, 1, 3'd3, 8'h13, 1, 6'd0, 63'd0, 0);
    conv("u64_msb",  64'h8000_0000_0000_0000, 0, 1, 3'd4, 8'h14, 0, 6'd0, 63'd0, 0);
    conv("z_u32",    64'd0, 0, 0, 3'd0, 8'h20, 0, 6'd0, 63'd0, 1);
    conv("z_s32",    64'd0, 1, 0, 3'd5, 8'h21, 0, 6'd0, 63'd0, 1);
    conv("z_u64",    64'd0, 0, 1, 3'd6, 8'h22, 0, 6'd0, 63'd0, 1);
    conv("z_s64",    64'd0, 1, 1, 3'd7, 8'h23, 0, 6'd0, 63'd0, 1);
    conv("s32_hi",   64'hDEAD_BEEF_0000_0000, 1, 0, 3'd2, 8'h24, 0, 6'd0, 63'd0, 1);
    conv("u32_max",  64'h1234_5678_FFFF_FFFF, 0, 0, 3'd1, 8'h30, 0, 6'd32, 63'h7FFF_FFFF_0000_0000, 0);
    conv("s32_min",  64'h0000_0000_8000_0000, 1, 0, 3'd0, 8'h31, 1, 6'd32, 63'd0, 0);
    conv("s64_m5",   64'hFFFF_FFFF_FFFF_FFFB, 1, 1, 3'd4, 8'h32, 1, 6'd61, 63'h2000_0000_0000_0000, 0);
    conv("u64_max",  64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 3'd3, 8'h33, 0, 6'd0, 63'h7FFF_FFFF_FFFF_FFFF, 0);
    conv("s64_pos",  64'h0000_0001_2345_6789, 1, 1, 3'd5, 8'h34, 0, 6'd31, 63'h11A2_B3C4_8000_0000, 0);

    // ---- backpressure: 4 ops, output stalled 3 cycles ----
    sv[0] = 64'd1; slzc[0] = 6'd63; stag[0] = 8'hA0;
    sv[1] = 64'd2; slzc[1] = 6'd62; stag[1] = 8'hA1;
    sv[2] = 64'd3; slzc[2] = 6'd62; stag[2] = 8'hA2;
    sv[3] = 64'd4; slzc[3] = 6'd61; stag[3] = 8'hA3;
    sent = 0; got = 0; held = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      out_ready_i = (held >= 3);
      if (sent < 4) drive(sv[sent], 0, 1, 3'd0, stag[sent]);
      else in_valid_i = 1'b0;
      #1;
      if (out_valid_o) begin
        if (!out_ready_i) begin
          chk("stall_tag",   64'(tag_o), 64'(stag[0]));
          chk("stall_lzc",   64'(lzc_o), 64'(slzc[0]));
          chk("stall_inrdy", 64'(in_ready_o), 64'd0);
          held++;
        end else begin
          chk("drain_tag", 64'(tag_o), 64'(stag[got]));
          chk("drain_lzc", 64'(lzc_o), 64'(slzc[got]));
          got++;
        end
      end
      acc = in_valid_i & in_ready_o;
      if (acc) sent++;
    end
    chk("drain_cnt", 64'(got), 64'd4);
    chk("stall_cycles", 64'(held), 64'd3);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_empty", 64'(out_valid_o), 64'd0);

    // ---- flush with 2 ops in flight ----
    @(negedge clk); drive(64'd7, 0, 1, 3'd1, 8'hB0);
    @(negedge clk); drive(64'd9, 0, 1, 3'd2, 8'hB1);
    @(negedge clk); in_valid_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_inrdy", 64'(in_ready_o), 64'd0);
    @(negedge clk); in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_vld0", 64'(out_valid_o), 64'd0);
    @(negedge clk);
    chk("flush_vld1", 64'(out_valid_o), 64'd0);
    conv("post_flush", 64'd6, 0, 1, 3'd6, 8'hB2, 0, 6'd61, 63'h4000_0000_0000_0000, 0);

    // ---- reset mid-stream ----
    @(negedge clk); drive(64'd5, 0, 1, 3'd1, 8'hC0);
    @(negedge clk); drive(64'd8, 0, 1, 3'd2, 8'hC1);
    @(negedge clk); in_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mrst_vld",  64'(out_valid_o), 64'd0);
    chk("mrst_tag",  64'(tag_o), 64'd0);
    chk("mrst_norm", 64'(norm_int_o), 64'd0);
    @(negedge clk);
    chk("mrst_vld1", 64'(out_valid_o), 64'd0);
    conv("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 3'd7, 8'hC2, 1, 6'd63, 63'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
